nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder that computes one 4-bit nibble per clock, LSB nibble first, with a registered carry between nibbles.
- Sits directly upstream of the team's 4-bit ripple-carry slice and feeds it.
- Accepts two operands on a Run pulse and returns a registered sum, carry-out and a one-cycle Done strobe.

---
 rtl/nibble_serial_adder_pkg.sv | 14 +
 rtl/nibble_serial_adder_nibble_add.sv | 20 ++
 rtl/nibble_serial_adder.sv | 129 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding
// and the slice width processed per clock.
// No ports; imported by nibble_add and nibble_serial_adder.
package lab4_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_nibble_add.sv
// Purely combinational 4-bit slice: {c,s} = a + b + cin.
// Ports: a, b (NIBBLE bits), cin -> s (NIBBLE bits), c (carry out).
// Same function as the downstream ripple-carry slice it mirrors.
module nibble_add
  import lab4_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              c
);

  logic [NIBBLE:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{NIBBLE{1'b0}}, cin};
  assign s   = sum[NIBBLE-1:0];
  assign c   = sum[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock LSB first, carry registered
// between nibbles. Run accepted only when Ready; Done pulses one cycle, NIB edges
// after the accepting edge. S/Cout change only on the ADD->DONE edge.
// Ports: Clk, Reset_n (async, active-low), Run, A, B, Cin -> Ready, Done, S, Cout.
// WIDTH must be a multiple of 4 and at least 8.
// Optional macro NIBBLE_SERIAL_SUB_EN adds input Sub (A-B, Cout=1 means no borrow)
// and output Ovf (signed overflow, registered with S).
module nibble_serial_adder
  import lab4_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             Sub,
  output logic             Ovf,
`endif
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int NIB = WIDTH / NIBBLE;
  localparam int CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t            state;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              c_r;
  logic [CW-1:0]     cnt;
  // The lowest nibble of the partial sum is always shifted out on the next step,
  // so only the upper WIDTH-NIBBLE bits need to be held between steps.
  logic [WIDTH-1:NIBBLE] p_r;

  logic [NIBBLE-1:0] nib_s;
  logic              nib_c;
  logic [WIDTH-1:0]  p_next;
  logic [WIDTH-1:0]  b_in;
  logic              c_in;

`ifdef NIBBLE_SERIAL_SUB_EN
  // Operand sign bits are shifted out of a_r/b_r during ADD, so keep copies.
  logic a_msb_r;
  logic b_msb_r;

  assign b_in = Sub ? ~B : B;
  assign c_in = Sub ? 1'b1 : Cin;
`else
  assign b_in = B;
  assign c_in = Cin;
`endif

  nibble_add u_nibble_add (
    .a  (a_r[NIBBLE-1:0]),
    .b  (b_r[NIBBLE-1:0]),
    .cin(c_r),
    .s  (nib_s),
    .c  (nib_c)
  );

  assign p_next = {nib_s, p_r};
  assign Ready  = (state == IDLE);
  assign Done   = (state == DONE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= 1'b0;
      cnt   <= '0;
      p_r   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      Ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            a_r   <= A;
            b_r   <= b_in;
            c_r   <= c_in;
            cnt   <= '0;
            p_r   <= '0;
            state <= ADD;
`ifdef NIBBLE_SERIAL_SUB_EN
            a_msb_r <= A[WIDTH-1];
            b_msb_r <= b_in[WIDTH-1];
`endif
          end
        end
        ADD: begin
          a_r <= a_r >> NIBBLE;
          b_r <= b_r >> NIBBLE;
          c_r <= nib_c;
          p_r <= p_next[WIDTH-1:NIBBLE];
          if (cnt == LAST) begin
            S     <= p_next;
            Cout  <= nib_c;
            state <= DONE;
`ifdef NIBBLE_SERIAL_SUB_EN
            Ovf <= (a_msb_r == b_msb_r) && (p_next[WIDTH-1] != a_msb_r);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector table,
// hand-written multi-cycle sequences and randomized operations against an
// arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Run;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Ready;
  logic         Done;
  logic [W-1:0] S;
  logic         Cout;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic         Sub;
  logic         Ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_s    = '0;
  logic         last_cout = 1'b0;

  always #5 Clk = ~Clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Run    (Run),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .Sub    (Sub),
    .Ovf    (Ovf),
`endif
    .Ready  (Ready),
    .Done   (Done),
    .S      (S),
    .Cout   (Cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, s}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
    int ua, ub, sa, sb, total, r;
    logic [W-1:0] s;
    logic cout, ovf;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      total = ua - ub;
      cout  = (ua >= ub);
      r     = sa - sb;
    end else begin
      total = ua + ub + int'(cin);
      cout  = (total > 65535);
      r     = sa + sb + int'(cin);
    end
    s   = total[W-1:0];
    ovf = (r > 32767) || (r < -32768);
    return {ovf, cout, s};
  endfunction

  // Issues one operation and waits (bounded) for Done. Checks busy behaviour,
  // result hold during ADD, latency and return to Ready.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output logic [W-1:0] s, output logic cout,
                        output logic ovf, output int lat);
    logic [W+1:0] exp;
    exp = ref_op(a, b, cin, sub);
    @(negedge Clk);
    A = a; B = b; Cin = cin; Run = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
    Sub = sub;
`endif
    @(posedge Clk);
    #1;
    Run = 1'b0;
    // Scramble inputs: the operation must use only the captured values.
    A = W'($urandom); B = W'($urandom); Cin = ~Cin;
`ifdef NIBBLE_SERIAL_SUB_EN
    Sub = ~Sub;
`endif
    lat = 0;
    while (!Done && lat < 20) begin
      check("busy_ready_low", 32'(Ready), 32'd0);
      check("s_hold", 32'(S), 32'(last_s));
      check("cout_hold", 32'(Cout), 32'(last_cout));
      @(posedge Clk);
      #1;
      lat++;
    end
    check("done_seen", 32'(Done), 32'd1);
    check("latency", 32'(lat), 32'(NIB));
    s    = S;
    cout = Cout;
`ifdef NIBBLE_SERIAL_SUB_EN
    ovf  = Ovf;
`else
    ovf  = 1'b0;
`endif
    last_s    = exp[W-1:0];
    last_cout = exp[W];
    @(posedge Clk);
    #1;
    check("ready_after_done", 32'(Ready), 32'd1);
    check("done_one_cycle", 32'(Done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc, ro;
    logic [W+1:0] exp;
    int           lat, dones;
    logic [W-1:0] ra, rb;
    logic         rcin, rsub;

    tbl[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, s: 16'h5555, cout: 1'b0};
    tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, cout: 1'b1};
    tbl[2] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, s: 16'h0000, cout: 1'b1};
    tbl[3] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, s: 16'h0000, cout: 1'b0};
    tbl[4] = '{a: 16'h8000, b: 16'h8000, cin: 1'b1, s: 16'h0001, cout: 1'b1};
    tbl[5] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, cout: 1'b0};

    Reset_n = 1'b0; Run = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    Sub = 1'b0;
`endif
    #12;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_s", 32'(S), 32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, rs, rc, ro, lat);
      check($sformatf("tbl%0d_s", i), 32'(rs), 32'(tbl[i].s));
      check($sformatf("tbl%0d_cout", i), 32'(rc), 32'(tbl[i].cout));
    end

    // Run pulsed again during ADD must be ignored: one Done, result of first op.
    @(negedge Clk);
    A = 16'h0001; B = 16'h0001; Cin = 1'b0; Run = 1'b1;
    @(posedge Clk);
    #1;
    Run = 1'b0;
    @(posedge Clk);
    #1;
    A = 16'h00FF; Run = 1'b1;
    @(posedge Clk);
    #1;
    Run = 1'b0;
    dones = 0;
    rs = '0;
    for (int k = 0; k < 12; k++) begin
      if (Done) begin
        dones++;
        rs = S;
      end
      @(posedge Clk);
      #1;
    end
    check("ignored_run_dones", 32'(dones), 32'd1);
    check("ignored_run_s", 32'(rs), 32'h0002);
    check("ignored_run_ready", 32'(Ready), 32'd1);

    // Asynchronous reset two edges after accept: immediate clear, no Done.
    @(negedge Clk);
    A = 16'h0F0F; B = 16'h0101; Cin = 1'b1; Run = 1'b1;
    @(posedge Clk);
    #1;
    Run = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check("midrst_ready", 32'(Ready), 32'd1);
    check("midrst_s", 32'(S), 32'd0);
    check("midrst_cout", 32'(Cout), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      if (Done) dones++;
      @(posedge Clk);
      #1;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    last_s = '0;
    last_cout = 1'b0;

    // Recovery after reset
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, rs, rc, ro, lat);
    check("recover_s", 32'(rs), 32'h5555);
    check("recover_cout", 32'(rc), 32'd0);

`ifdef NIBBLE_SERIAL_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rc, ro, lat);
    check("sub1_s", 32'(rs), 32'hFFFE);
    check("sub1_cout", 32'(rc), 32'd0);
    check("sub1_ovf", 32'(ro), 32'd0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat);
    check("sub2_s", 32'(rs), 32'h7FFF);
    check("sub2_cout", 32'(rc), 32'd1);
    check("sub2_ovf", 32'(ro), 32'd1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    check("add_ovf", 32'(ro), 32'd1);
`endif

    // Randomized operations against the reference model
    for (int n = 0; n < 150; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rcin = 1'($urandom_range(0, 1));
`ifdef NIBBLE_SERIAL_SUB_EN
      rsub = 1'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      exp = ref_op(ra, rb, rcin, rsub);
      run_op(ra, rb, rcin, rsub, rs, rc, ro, lat);
      check("rand_s", 32'(rs), 32'(exp[W-1:0]));
      check("rand_cout", 32'(rc), 32'(exp[W]));
`ifdef NIBBLE_SERIAL_SUB_EN
      check("rand_ovf", 32'(ro), 32'(exp[W+1]));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
